vga_plot_arbiter: RTL
=====================

// Module: vga_plot_arbiter
// PURPOSE
//  Downstream of the UI drawing units (start banner, game graphics). Merges two
//  x/y/color/plot streams into the single vga_adapter write port. Buffers
//  colliding writes in a small FIFO and provides a full-screen clear sweep.
//  Output feeds the vga_adapter's x, y, colour and plot inputs directly.
// PARAMETERS
//  FIFO_DEPTH   4       source-B skid buffer entries; power of 2, >=2
//  X_MAX        159     last valid column; larger x is discarded
//  Y_MAX        119     last valid row; larger y is discarded
//  CLEAR_COLOR  3'b000  colour written by the clear sweep
// PORTS
//  clk         in   1  system clock (CLOCK_50)
//  reset_n     in   1  asynchronous, active-low reset
//  a_plot      in   1  source A write strobe (priority source)
//  a_x         in   8  source A column
//  a_y         in   7  source A row
//  a_color     in   3  source A colour
//  b_plot      in   1  source B write strobe (buffered source)
//  b_x         in   8  source B column
//  b_y         in   7  source B row
//  b_color     in   3  source B colour
//  clear_req   in   1  single-cycle request for a full-screen clear
//  vga_x       out  8  column to vga_adapter
//  vga_y       out  7  row to vga_adapter
//  vga_color   out  3  colour to vga_adapter
//  vga_plot    out  1  write enable to vga_adapter
//  clear_busy  out  1  high while the clear sweep runs
//  overflow    out  1  sticky; set when a B pixel is dropped
// BEHAVIOUR
//  - Reset (async): all outputs 0; FIFO empty; state PASS; sweep counters 0.
//  - All outputs are registered. An accepted pixel appears 1 cycle after its strobe.
//  - Pixel validity: a pixel with x>X_MAX or y>Y_MAX is discarded on input.
//    It is never plotted or buffered and is not counted as a drop.
//  - FSM states: PASS and CLEAR.
//    PASS -> CLEAR when clear_req=1.
//    CLEAR -> PASS the cycle after pixel (X_MAX,Y_MAX) is output.
//  - PASS arbitration, one output pixel per cycle:
//    a_plot valid: output A; a valid b_plot is pushed to the FIFO.
//    else FIFO non-empty: output FIFO head (pop); a valid b_plot is pushed in the same cycle.
//    else b_plot valid: output B directly (bypass; FIFO untouched).
//    else vga_plot=0; vga_x/vga_y/vga_color hold their last values.
//  - Ordering: B pixels are always output in arrival order.
//  - FIFO full with a push and no pop: the incoming B pixel is dropped and overflow<=1.
//    overflow stays set until reset. Push and pop in the same cycle while full is legal.
//  - clear_req in PASS: that cycle's pixels are processed normally. The FIFO is flushed
//    on entry to CLEAR; flushed entries are not counted as drops.
//  - CLEAR: sweeps x 0..X_MAX inner and y 0..Y_MAX outer, one pixel per cycle.
//    vga_plot=1, vga_color=CLEAR_COLOR; (X_MAX+1)*(Y_MAX+1) cycles (19200 at defaults).
//    clear_busy=1 throughout. A/B inputs are ignored (not buffered, not counted).
//    clear_req is ignored while in CLEAR.
//  - reset_n low mid-sweep or mid-burst: immediate return to reset state; no resume.
// CONFIGURATION
//  PLOT_DROP_COUNT_EN defined: adds output drop_count [7:0].
//    Reset 0; +1 per dropped B pixel; saturates at 255.
//  PLOT_DROP_COUNT_EN undefined: no drop_count port; only sticky overflow is provided.
// STRUCTURE
//  Package vga_plot_pkg:
//    X_W=8, Y_W=7, C_W=3, SCREEN_W=160, SCREEN_H=120.
//    Typedef pixel_t {x, y, color}, 18 bits.
//    FSM state enum {PASS, CLEAR}.
//  Sub-module plot_fifo: synchronous FIFO of pixel_t, depth FIFO_DEPTH.
//    Ports: push, pop, flush, full, empty, head. Same clk/reset_n.
// TESTING
//  1. a_plot=1 at (70,60,010) for 1 cycle -> next cycle vga_plot=1, (70,60,010); then vga_plot=0.
//  2. a_plot and b_plot both 1 for 3 cycles, then idle -> 6 consecutive plots:
//     A0 A1 A2 B0 B1 B2.
//  3. Both strobes 1 for 6 cycles, FIFO_DEPTH=4 -> B0..B3 plotted after A; B4, B5 lost;
//     overflow=1; drop_count=2 when PLOT_DROP_COUNT_EN is defined.
//  4. clear_req pulse -> clear_busy=1 for 19200 cycles; first output (0,0,000), last (159,119,000).
//     a_plot during the sweep is never output.
//  5. a_plot with a_x=200 -> vga_plot stays 0 and no FIFO change; b_y=120 -> likewise.
//  6. reset_n=0 at sweep pixel 5000 -> outputs 0 with no clock edge; after release,
//     a_plot output normally and clear_busy=0.

Source files
------------

// File: rtl/vga_plot_pkg.sv
// Shared types and screen constants for the VGA plot arbiter.
package vga_plot_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        PASS  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // True when the pixel lies inside the visible window.
    function automatic logic in_bounds(input pixel_t p, input int x_max, input int y_max);
        return (int'(p.x) <= x_max) && (int'(p.y) <= y_max);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous skid FIFO of pixels for the buffered (B) source.
// Push while full is ignored unless a pop happens in the same cycle.
// Flush empties the FIFO and takes priority over push/pop.
module plot_fifo
    import vga_plot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  pixel_t din,
    output logic   full,
    output logic   empty,
    output pixel_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    pixel_t          mem_q [DEPTH];
    pixel_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Merges a priority pixel stream (A) and a buffered stream (B) into the
// vga_adapter write port, with a full-screen clear sweep.
// Optional: define PLOT_DROP_COUNT_EN to add a saturating drop_count output.
module vga_plot_arbiter
    import vga_plot_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         X_MAX       = SCREEN_W - 1,
    parameter int         Y_MAX       = SCREEN_H - 1,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           a_plot,
    input  logic [X_W-1:0] a_x,
    input  logic [Y_W-1:0] a_y,
    input  logic [C_W-1:0] a_color,
    input  logic           b_plot,
    input  logic [X_W-1:0] b_x,
    input  logic [Y_W-1:0] b_y,
    input  logic [C_W-1:0] b_color,
    input  logic           clear_req,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_color,
    output logic           vga_plot,
    output logic           clear_busy,
`ifdef PLOT_DROP_COUNT_EN
    output logic [7:0]     drop_count,
`endif
    output logic           overflow
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    state_t         state_q, state_d;
    pixel_t         out_q, out_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;

    pixel_t a_pix, b_pix, fifo_head;
    logic   a_valid, b_valid;
    logic   f_push, f_pop, f_flush, f_full, f_empty, drop;

    assign a_pix   = '{x: a_x, y: a_y, color: a_color};
    assign b_pix   = '{x: b_x, y: b_y, color: b_color};
    assign a_valid = a_plot && in_bounds(a_pix, X_MAX, Y_MAX);
    assign b_valid = b_plot && in_bounds(b_pix, X_MAX, Y_MAX);
    assign drop    = f_push && f_full && !f_pop;

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (f_push),
        .pop     (f_pop),
        .flush   (f_flush),
        .din     (b_pix),
        .full    (f_full),
        .empty   (f_empty),
        .head    (fifo_head)
    );

    // Arbitration in PASS, raster sweep in CLEAR; all outputs registered.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        ovf_d   = ovf_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        f_push  = 1'b0;
        f_pop   = 1'b0;
        f_flush = 1'b0;
        case (state_q)
            PASS: begin
                if (a_valid) begin
                    out_d  = a_pix;
                    plot_d = 1'b1;
                    f_push = b_valid;
                end else if (!f_empty) begin
                    out_d  = fifo_head;
                    plot_d = 1'b1;
                    f_pop  = 1'b1;
                    f_push = b_valid;
                end else if (b_valid) begin
                    out_d  = b_pix;
                    plot_d = 1'b1;
                end
                if (clear_req) begin
                    // Flushed entries are discarded silently, not counted as drops.
                    state_d = CLEAR;
                    f_flush = 1'b1;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            CLEAR: begin
                out_d  = '{x: cx_q, y: cy_q, color: CLEAR_COLOR};
                plot_d = 1'b1;
                busy_d = 1'b1;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = '0;
                        state_d = PASS;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            default: state_d = PASS;
        endcase
        if (drop && !f_flush) ovf_d = 1'b1;
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PASS;
            out_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

`ifdef PLOT_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped B pixels.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && !f_flush && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

    assign vga_x      = out_q.x;
    assign vga_y      = out_q.y;
    assign vga_color  = out_q.color;
    assign vga_plot   = plot_q;
    assign clear_busy = busy_q;
    assign overflow   = ovf_q;

endmodule
